// File: rtl/mac_phase_sequencer_if.sv
// Control/handshake bundle between top-level control and the MAC phase sequencer.
// The master side issues runs and streams beats; the slave side is the sequencer.
interface mac_phase_sequencer_if #(
    parameter int N_MACS = 4,
    parameter int CNT_W  = 8
);
    localparam int H     = N_MACS / 2;
    localparam int IDX_W = (H > 1) ? $clog2(H) : 1;

    logic                start;
    logic                clear_all;
    logic [CNT_W-1:0]    len_in;
    logic                in_valid;
    logic                in_ready;
    logic [N_MACS-1:0]   mac_clr;
    logic [N_MACS-1:0]   mac_en;
    logic                layer_sel;
    logic [IDX_W-1:0]    layer_idx;
    logic [N_MACS-1:0]   valid_out;
    logic                busy;
    logic                done;
    logic                start_err;

    modport master (
        output start, clear_all, len_in, in_valid,
        input  in_ready, mac_clr, mac_en, layer_sel, layer_idx,
               valid_out, busy, done, start_err
    );

    modport slave (
        input  start, clear_all, len_in, in_valid,
        output in_ready, mac_clr, mac_en, layer_sel, layer_idx,
               valid_out, busy, done, start_err
    );
endinterface

// File: rtl/mac_phase_sequencer.sv
// Two-phase sequencer for a systolic MAC array: LOAD streams a_in into the lower half,
// LAYER feeds lower-half results into the upper half, each with a skewed enable wave.
module mac_phase_sequencer #(
    parameter int N_MACS = 4,
    parameter int CNT_W  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    mac_phase_sequencer_if.slave   bus
);
    localparam int H     = N_MACS / 2;
    localparam int IDX_W = (H > 1) ? $clog2(H) : 1;
    localparam int LW    = (H > 1) ? (H - 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] H_M1     = CNT_W'(H - 1);

    typedef enum logic [2:0] {
        S_IDLE        = 3'd0,
        S_CLR         = 3'd1,
        S_LOAD        = 3'd2,
        S_LOAD_DRAIN  = 3'd3,
        S_LAYER       = 3'd4,
        S_LAYER_DRAIN = 3'd5,
        S_DONE        = 3'd6
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_m1_q, len_m1_d;
    logic [LW-1:0]    en_lo_q, en_lo_d;
    logic [LW-1:0]    en_hi_q, en_hi_d;
    logic [H-1:0]     last_lo_q, last_lo_d;
    logic [H-1:0]     last_hi_q, last_hi_d;
    logic             mac_clr_q, mac_clr_d;
    logic             start_err_q, start_err_d;

    logic              beat_en_s;
    logic              load_last_s;
    logic              phase_end_s;
    logic              layer_en_s;
    logic              layer_last_s;
    logic [N_MACS-1:0] mac_en_s;

    // Beat qualification and phase-end decodes, all from registered state.
    assign beat_en_s    = bus.in_valid & (state_q == S_LOAD);
    assign load_last_s  = beat_en_s & (cnt_q == len_m1_q);
    assign phase_end_s  = (cnt_q == H_M1);
    assign layer_en_s   = (state_q == S_LAYER);
    assign layer_last_s = layer_en_s & phase_end_s;

    // Next-state, beat counter and run-length latch; clear_all overrides everything.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        len_m1_d = len_m1_q;
        if (bus.clear_all) begin
            state_d = S_IDLE;
            cnt_d   = CNT_ZERO;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_d  = S_CLR;
                        cnt_d    = CNT_ZERO;
                        len_m1_d = (bus.len_in == CNT_ZERO) ? CNT_ZERO : (bus.len_in - CNT_ONE);
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_CLR: begin
                    state_d = S_LOAD;
                    cnt_d   = CNT_ZERO;
                end
                S_LOAD: begin
                    if (load_last_s) begin
                        state_d = S_LOAD_DRAIN;
                        cnt_d   = CNT_ZERO;
                    end else if (beat_en_s) begin
                        cnt_d = cnt_q + CNT_ONE;
                    end else begin
                        cnt_d = cnt_q;
                    end
                end
                S_LOAD_DRAIN: begin
                    if (phase_end_s) begin
                        state_d = S_LAYER;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_LAYER: begin
                    if (phase_end_s) begin
                        state_d = S_LAYER_DRAIN;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_LAYER_DRAIN: begin
                    if (phase_end_s) begin
                        state_d = S_DONE;
                        cnt_d   = CNT_ZERO;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = CNT_ZERO;
                end
            endcase
        end
    end

    // Skew delay lines: enables ripple one MAC per cycle, last-beat markers trail them by one.
    always_comb begin
        en_lo_d     = {LW{1'b0}};
        en_hi_d     = {LW{1'b0}};
        last_lo_d   = {H{1'b0}};
        last_hi_d   = {H{1'b0}};
        mac_clr_d   = bus.clear_all | (state_d == S_CLR);
        start_err_d = bus.start & (state_q != S_IDLE);
        if (bus.clear_all) begin
            en_lo_d   = {LW{1'b0}};
            en_hi_d   = {LW{1'b0}};
            last_lo_d = {H{1'b0}};
            last_hi_d = {H{1'b0}};
        end else begin
            en_lo_d[0]   = beat_en_s;
            en_hi_d[0]   = layer_en_s;
            last_lo_d[0] = load_last_s;
            last_hi_d[0] = layer_last_s;
            for (int i = 1; i < LW; i++) begin
                en_lo_d[i] = en_lo_q[i-1];
                en_hi_d[i] = en_hi_q[i-1];
            end
            for (int i = 1; i < H; i++) begin
                last_lo_d[i] = last_lo_q[i-1];
                last_hi_d[i] = last_hi_q[i-1];
            end
        end
    end

    // State and delay-line registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= {CNT_W{1'b0}};
            len_m1_q    <= {CNT_W{1'b0}};
            en_lo_q     <= {LW{1'b0}};
            en_hi_q     <= {LW{1'b0}};
            last_lo_q   <= {H{1'b0}};
            last_hi_q   <= {H{1'b0}};
            mac_clr_q   <= 1'b0;
            start_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            len_m1_q    <= len_m1_d;
            en_lo_q     <= en_lo_d;
            en_hi_q     <= en_hi_d;
            last_lo_q   <= last_lo_d;
            last_hi_q   <= last_hi_d;
            mac_clr_q   <= mac_clr_d;
            start_err_q <= start_err_d;
        end
    end

    // Per-MAC enables; MAC 0 follows the accepted beat in the same cycle as its data.
    always_comb begin
        mac_en_s    = {N_MACS{1'b0}};
        mac_en_s[0] = beat_en_s;
        mac_en_s[H] = layer_en_s;
        for (int i = 1; i < H; i++) begin
            mac_en_s[i]     = en_lo_q[i-1];
            mac_en_s[H + i] = en_hi_q[i-1];
        end
    end

    assign bus.in_ready  = (state_q == S_LOAD);
    assign bus.mac_en    = mac_en_s;
    assign bus.mac_clr   = {N_MACS{mac_clr_q}};
    assign bus.valid_out = {last_hi_q, last_lo_q};
    assign bus.layer_sel = (state_q == S_LAYER) | (state_q == S_LAYER_DRAIN);
    assign bus.layer_idx = layer_en_s ? cnt_q[IDX_W-1:0] : {IDX_W{1'b0}};
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.start_err = start_err_q;
endmodule

// File: tb/tb_mac_phase_sequencer.sv
// Scoreboard bench: a timing model derived from the run parameters pushes the expected
// output vector for every cycle; the sampled DUT outputs are popped and compared mid-cycle.
module tb_mac_phase_sequencer;
    localparam int N_MACS = 4;
    localparam int CNT_W  = 8;
    localparam int H      = N_MACS / 2;

    typedef struct packed {
        logic [3:0] clr;
        logic [3:0] en;
        logic [3:0] vo;
        logic       sel;
        logic       idx;
        logic       busy;
        logic       done;
        logic       serr;
        logic       rdy;
    } obs_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;
    obs_t exp_q[$];

    mac_phase_sequencer_if #(.N_MACS(N_MACS), .CNT_W(CNT_W)) bus ();

    mac_phase_sequencer #(.N_MACS(N_MACS), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t sample_obs();
        obs_t o;
        o.clr  = bus.mac_clr;
        o.en   = bus.mac_en;
        o.vo   = bus.valid_out;
        o.sel  = bus.layer_sel;
        o.idx  = bus.layer_idx;
        o.busy = bus.busy;
        o.done = bus.done;
        o.serr = bus.start_err;
        o.rdy  = bus.in_ready;
        return o;
    endfunction

    task automatic check_eq(input string tag, input obs_t act, input obs_t req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got clr=%h en=%h vo=%h sel=%b idx=%b busy=%b done=%b serr=%b rdy=%b, need clr=%h en=%h vo=%h sel=%b idx=%b busy=%b done=%b serr=%b rdy=%b",
                     tag, act.clr, act.en, act.vo, act.sel, act.idx, act.busy, act.done, act.serr, act.rdy,
                     req.clr, req.en, req.vo, req.sel, req.idx, req.busy, req.done, req.serr, req.rdy);
        end
    endtask

    function automatic bit iv_at(input int c, input int stall_at, input int stall_n);
        return !(stall_at >= 0 && c >= stall_at && c < stall_at + stall_n);
    endfunction

    // Cycle c = 0 is the CLR cycle; LOAD begins at c = 1.
    task automatic run_seq(input string name, input int len, input int stall_at, input int stall_n,
                           input int abort_at, input int serr_at, input int ncyc);
        int   len_eff, cnt, t_last, ls, fin;
        bit   acc [0:127];
        obs_t e;
        len_eff = (len == 0) ? 1 : len;
        cnt     = 0;
        t_last  = 0;
        for (int c = 0; c < 128; c++) acc[c] = 1'b0;
        for (int c = 1; c < 128; c++) begin
            if (cnt < len_eff && iv_at(c, stall_at, stall_n)) begin
                acc[c] = 1'b1;
                cnt++;
                t_last = c;
            end
        end
        ls  = t_last + H + 1;
        fin = ls + 2 * H;

        @(posedge clk); #1;
        bus.start     = 1'b1;
        bus.len_in    = CNT_W'(len);
        bus.in_valid  = 1'b0;
        bus.clear_all = 1'b0;
        for (int c = 0; c < ncyc; c++) begin
            @(posedge clk); #1;
            bus.start     = (c == serr_at);
            bus.clear_all = (c == abort_at);
            bus.in_valid  = iv_at(c, stall_at, stall_n);
            bus.len_in    = CNT_W'($urandom);
            e = '0;
            if (abort_at < 0 || c <= abort_at) begin
                e.rdy   = (c >= 1 && c <= t_last);
                e.en[0] = acc[c];
                e.en[1] = (c >= 1) && acc[c-1];
                for (int k = 0; k < H; k++) begin
                    e.vo[k]     = (c == t_last + 1 + k);
                    e.en[H + k] = (c >= ls + k && c < ls + k + H);
                    e.vo[H + k] = (c == ls + H + k);
                end
                e.idx  = (c >= ls && c < ls + H) ? 1'(c - ls) : 1'b0;
                e.sel  = (c >= ls && c < ls + 2 * H);
                e.done = (c == fin);
                e.busy = (c <= fin);
            end
            if (c == 0 || (abort_at >= 0 && c == abort_at + 1)) e.clr = 4'hF;
            if (serr_at >= 0 && c == serr_at + 1) e.serr = 1'b1;
            exp_q.push_back(e);
            @(negedge clk);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s c%0d: scoreboard empty", name, c);
            end else begin
                check_eq($sformatf("%s c%0d", name, c), sample_obs(), exp_q.pop_front());
            end
        end
        bus.start     = 1'b0;
        bus.clear_all = 1'b0;
        bus.in_valid  = 1'b0;
    endtask

    initial begin
        obs_t zero_o, clr_o;
        n_cmp = 0;
        n_bad = 0;
        zero_o = '0;
        clr_o  = '0;
        clr_o.clr = 4'hF;
        bus.start = 1'b0; bus.clear_all = 1'b0; bus.len_in = 8'd0; bus.in_valid = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 check_eq("reset_hold", sample_obs(), zero_o);
        @(negedge clk) rst = 1'b1;
        @(negedge clk) check_eq("reset_idle", sample_obs(), zero_o);

        run_seq("basic_len3",  3, -1, 0, -1, -1, 12);
        run_seq("stall2",      3,  2, 2, -1, -1, 14);
        run_seq("len0",        0, -1, 0, -1, -1, 10);
        run_seq("abort_layer", 3, -1, 0,  7, -1, 12);
        run_seq("after_abort", 3, -1, 0, -1, -1, 12);
        run_seq("start_err",   3, -1, 0, -1,  2, 12);
        run_seq("len5_stall",  5,  3, 4, -1, -1, 18);

        // start together with clear_all in IDLE: clear only, no run.
        @(posedge clk); #1 bus.start = 1'b1; bus.clear_all = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.clear_all = 1'b0;
        @(negedge clk) check_eq("idle_start_clear", sample_obs(), clr_o);
        @(negedge clk) check_eq("idle_stays", sample_obs(), zero_o);

        // Asynchronous reset in LOAD_DRAIN (c = 4 for len = 3).
        @(posedge clk); #1 bus.start = 1'b1; bus.len_in = 8'd3;
        @(posedge clk); #1 bus.start = 1'b0; bus.in_valid = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        #1 check_eq("async_rst_now", sample_obs(), zero_o);
        @(negedge clk) rst = 1'b1;
        bus.in_valid = 1'b0;
        @(negedge clk) check_eq("rst_release", sample_obs(), zero_o);
        run_seq("post_reset", 3, -1, 0, -1, -1, 12);

        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries left, need 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
